// File: rtl/flags_cond_unit_if.sv
// Bus between the EX/issue stages and flags_cond_unit.
// The pipeline side (master) drives ALU flags, pipeline control and the B.cond request.
// The unit side (slave) returns the architectural flags, the hazard hold and the branch decision.
interface flags_cond_if;
  // Pipeline control
  logic       stall;
  logic       flush;
  // EX-stage ALU results
  logic       ex_valid;
  logic       write_flags;
  logic       negative;
  logic       zero_flag;
  logic       carry;
  logic       overflow;
  // Issue-stage B.cond
  logic       bcond_req;
  logic [3:0] cond;
  // Unit outputs
  logic [3:0] nzcv;
  logic       cond_hold;
  logic       taken_valid;
  logic       taken;

  modport master (
    output stall,
    output flush,
    output ex_valid,
    output write_flags,
    output negative,
    output zero_flag,
    output carry,
    output overflow,
    output bcond_req,
    output cond,
    input  nzcv,
    input  cond_hold,
    input  taken_valid,
    input  taken
  );

  modport slave (
    input  stall,
    input  flush,
    input  ex_valid,
    input  write_flags,
    input  negative,
    input  zero_flag,
    input  carry,
    input  overflow,
    input  bcond_req,
    input  cond,
    output nzcv,
    output cond_hold,
    output taken_valid,
    output taken
  );
endinterface

// File: rtl/flags_cond_unit.sv
// flags_cond_unit: architectural NZCV register plus B.cond resolution.
// Holds {N,Z,C,V}, detects the flag RAW hazard between a flag-setting op in EX and a
// B.cond in issue, and produces a registered (1-cycle latency) branch decision.
// Optional feature macro: FLAG_BYPASS_EN -- forwards EX flags into the condition
// evaluation instead of requesting a hold.
module flags_cond_unit #(
  parameter logic [3:0] RESET_NZCV = 4'b0000
) (
  input logic         clk,
  input logic         reset,
  flags_cond_if.slave bus
);

  logic [3:0] nzcv_q, nzcv_d;
  logic       taken_valid_q, taken_valid_d;
  logic       taken_q, taken_d;

  logic [3:0] alu_flags;
  logic       ex_sets_flags;
  logic       flag_we;
  logic       hold;
  logic       eval;
  logic [3:0] flag_src;
  logic       cond_true;

  assign alu_flags = {bus.negative, bus.zero_flag, bus.carry, bus.overflow};

  // A live (unflushed) flag setter sitting in EX this cycle.
  assign ex_sets_flags = bus.ex_valid & bus.write_flags & ~bus.flush;
  assign flag_we       = ex_sets_flags & ~bus.stall;

`ifdef FLAG_BYPASS_EN
  // Hazard resolved by forwarding the EX flags; no hold ever requested.
  always_comb begin
    hold     = 1'b0;
    flag_src = ex_sets_flags ? alu_flags : nzcv_q;
  end
`else
  // Hazard resolved by holding the B.cond until the setter has retired its flags.
  always_comb begin
    hold     = bus.bcond_req & ex_sets_flags;
    flag_src = nzcv_q;
  end
`endif

  assign eval = bus.bcond_req & ~hold;

  // Condition decode: odd codes invert the even predicate, except NV which is always true.
  always_comb begin
    logic n, z, c, v;
    logic base;
    {n, z, c, v} = flag_src;
    base = 1'b1;
    case (bus.cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = ~(n ^ v);
      3'd6:    base = ~z & ~(n ^ v);
      default: base = 1'b1;
    endcase
    if (bus.cond == 4'hF) begin
      cond_true = 1'b1;
    end else begin
      cond_true = base ^ bus.cond[0];
    end
  end

  // Next-state: flush overrides stall; stall freezes everything else.
  always_comb begin
    nzcv_d        = nzcv_q;
    taken_valid_d = taken_valid_q;
    taken_d       = taken_q;
    if (flag_we) begin
      nzcv_d = alu_flags;
    end
    if (bus.flush) begin
      taken_valid_d = 1'b0;
      taken_d       = 1'b0;
    end else if (!bus.stall) begin
      taken_valid_d = eval;
      taken_d       = eval & cond_true;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nzcv_q        <= RESET_NZCV;
      taken_valid_q <= 1'b0;
      taken_q       <= 1'b0;
    end else begin
      nzcv_q        <= nzcv_d;
      taken_valid_q <= taken_valid_d;
      taken_q       <= taken_d;
    end
  end

  assign bus.nzcv        = nzcv_q;
  assign bus.cond_hold   = hold;
  assign bus.taken_valid = taken_valid_q;
  assign bus.taken       = taken_q;

endmodule

// File: tb/tb_flags_cond_unit.sv
// Self-checking bench for flags_cond_unit: directed scenarios followed by randomized
// traffic, all compared against a behavioural model of the flag/branch rules.
module tb_flags_cond_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  // Reference state
  logic [3:0] m_nzcv;
  logic       m_tv;
  logic       m_tk;

  flags_cond_if bus ();

  flags_cond_unit #(
    .RESET_NZCV(4'b0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural meaning of each condition code.
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic drive(input logic ev, input logic wf, input logic [3:0] fl, input logic br,
                       input logic [3:0] c, input logic st, input logic fu);
    bus.ex_valid    = ev;
    bus.write_flags = wf;
    {bus.negative, bus.zero_flag, bus.carry, bus.overflow} = fl;
    bus.bcond_req   = br;
    bus.cond        = c;
    bus.stall       = st;
    bus.flush       = fu;
  endtask

  // One clock: check the hold, advance model and DUT, then compare registered outputs.
  task automatic step(input string tag);
    logic       setter, exp_hold, do_eval;
    logic [3:0] fsrc, alu;
    #1;
    alu    = {bus.negative, bus.zero_flag, bus.carry, bus.overflow};
    setter = bus.ex_valid && bus.write_flags && !bus.flush;
`ifdef FLAG_BYPASS_EN
    exp_hold = 1'b0;
    fsrc     = setter ? alu : m_nzcv;
`else
    exp_hold = bus.bcond_req && setter;
    fsrc     = m_nzcv;
`endif
    check_eq({tag, "_hold"}, bus.cond_hold, exp_hold);
    do_eval = bus.bcond_req && !exp_hold;
    @(posedge clk);
    if (bus.flush) begin
      m_tv = 1'b0;
      m_tk = 1'b0;
    end else if (!bus.stall) begin
      m_tv = do_eval;
      m_tk = do_eval && cond_holds(bus.cond, fsrc);
      if (setter) m_nzcv = alu;
    end
    #1;
    check_eq({tag, "_nzcv"}, bus.nzcv, m_nzcv);
    check_eq({tag, "_tv"}, bus.taken_valid, m_tv);
    check_eq({tag, "_tk"}, bus.taken, m_tk);
  endtask

  // Reset pulse placed between clock edges; outputs must clear without a clock.
  task automatic mid_reset(input string tag);
    #1 reset = 1'b0;
    #1;
    m_nzcv = 4'b0000;
    m_tv   = 1'b0;
    m_tk   = 1'b0;
    check_eq({tag, "_nzcv"}, bus.nzcv, 4'b0000);
    check_eq({tag, "_tv"}, bus.taken_valid, 1'b0);
    check_eq({tag, "_tk"}, bus.taken, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_nzcv   = 4'b0000;
    m_tv     = 1'b0;
    m_tk     = 1'b0;
    reset    = 1'b0;
    drive(0, 0, 4'h0, 0, 4'h0, 0, 0);
    #12;
    check_eq("rst_nzcv", bus.nzcv, 4'b0000);
    check_eq("rst_tv", bus.taken_valid, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Set nzcv=1111 and get a decision in flight, then reset mid-cycle.
    drive(1, 1, 4'hF, 0, 4'h0, 0, 0); step("t1_set");
    drive(0, 0, 4'h0, 1, 4'h0, 0, 0); step("t1_br");
    check_eq("t1_pre_nzcv", bus.nzcv, 4'b1111);
    check_eq("t1_pre_tv", bus.taken_valid, 1'b1);
    drive(0, 0, 4'h0, 0, 4'h0, 0, 0);
    mid_reset("t1_rst");

    // Flag write then EQ / NE.
    @(posedge clk); #1;
    drive(1, 1, 4'b0110, 0, 4'h0, 0, 0); step("t2_w");
    check_eq("t2_nzcv_const", bus.nzcv, 4'b0110);
    drive(0, 0, 4'h0, 1, 4'h0, 0, 0); step("t2_eq");
    check_eq("t2_eq_const", {bus.taken_valid, bus.taken}, 2'b11);
    drive(0, 0, 4'h0, 1, 4'h1, 0, 0); step("t2_ne");
    check_eq("t2_ne_const", {bus.taken_valid, bus.taken}, 2'b10);

    // Hazard: NE in issue while EX sets Z.
    drive(1, 1, 4'b0000, 0, 4'h0, 0, 0); step("t3_clr");
    drive(1, 1, 4'b0100, 1, 4'h1, 0, 0);
    #1;
`ifdef FLAG_BYPASS_EN
    check_eq("t3_hold_const", bus.cond_hold, 1'b0);
`else
    check_eq("t3_hold_const", bus.cond_hold, 1'b1);
`endif
    step("t3_haz");
`ifndef FLAG_BYPASS_EN
    drive(0, 0, 4'h0, 1, 4'h1, 0, 0); step("t3_bub");
`endif
    check_eq("t3_res_const", {bus.taken_valid, bus.taken}, 2'b10);

    // Signed comparisons with N=1,V=1,Z=0.
    drive(1, 1, 4'b1001, 0, 4'h0, 0, 0); step("t4_w");
    drive(0, 0, 4'h0, 1, 4'hC, 0, 0); step("t4_gt");
    check_eq("t4_gt_const", bus.taken, 1'b1);
    drive(0, 0, 4'h0, 1, 4'hB, 0, 0); step("t4_lt");
    drive(0, 0, 4'h0, 1, 4'hD, 0, 0); step("t4_le");
    drive(0, 0, 4'h0, 1, 4'hF, 0, 0); step("t4_nv");

    // Flush, alone and with stall.
    drive(1, 1, 4'hF, 1, 4'h0, 0, 1); step("t5_fl");
    check_eq("t5_fl_nzcv_const", bus.nzcv, 4'b1001);
    drive(0, 0, 4'h0, 1, 4'hE, 0, 0); step("t5_al");
    drive(1, 1, 4'hF, 1, 4'h0, 1, 1); step("t5_flst");
    check_eq("t5_flst_tv_const", bus.taken_valid, 1'b0);

    // Freeze for three cycles with a setter in EX, then release.
    drive(0, 0, 4'h0, 1, 4'hE, 0, 0); step("t6_al");
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 4'b0011, 0, 4'h0, 1, 0); step("t6_st");
    end
    check_eq("t6_frozen_const", {bus.nzcv, bus.taken_valid, bus.taken}, 6'b1001_11);
    drive(1, 1, 4'b0011, 0, 4'h0, 0, 0); step("t6_rel");
    check_eq("t6_rel_const", {bus.nzcv, bus.taken_valid}, 5'b0011_0);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom),
            1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 60) == 0) mid_reset("rnd_rst");
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
